// File: rtl/uart_clock_arbiter_pkg.sv
// Shared definitions for the UART clock arbiter: the FSM state encoding and
// the default parameter values used by the interface, the divider and the top.
package uart_clock_arbiter_pkg;

  localparam int DEF_NREQ     = 2;   // requesters sharing the divider (2..8)
  localparam int DEF_PERIOD_W = 32;  // tick period width, in hwclk cycles
  localparam int DEF_COUNT_W  = 8;   // tick-count request width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/uart_clock_arbiter_if.sv
// Bundle of the requester-facing signals of the UART clock arbiter.
//   req     : per-requester level request, held until done or abandoned
//   period  : per-requester tick period (slice i belongs to requester i)
//   nticks  : per-requester number of ticks wanted
//   grant   : one-hot owner of the divider, or all zero
//   tick    : one-cycle pulse at each period expiry
//   clk_out : square wave toggling on every tick
//   done    : one-cycle pulse to the owner on completion
//   busy    : high whenever the arbiter is not idle
// master = requester side, slave = arbiter side.
interface uart_clock_arbiter_if
  import uart_clock_arbiter_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int COUNT_W  = DEF_COUNT_W
);

  logic [NREQ-1:0]          req;
  logic [NREQ*PERIOD_W-1:0] period;
  logic [NREQ*COUNT_W-1:0]  nticks;
  logic [NREQ-1:0]          grant;
  logic                     tick;
  logic                     clk_out;
  logic [NREQ-1:0]          done;
  logic                     busy;

  modport master (
    output req, period, nticks,
    input  grant, tick, clk_out, done, busy
  );

  modport slave (
    input  req, period, nticks,
    output grant, tick, clk_out, done, busy
  );

endinterface

// File: rtl/uart_clock_arbiter_tick_div.sv
// Tick divider shared by all requesters.
//   hwclk, resetn : clock and async active-low reset
//   clear         : the current cycle is LOAD, so the next running cycle is count 0
//   run           : the next cycle is a running (RUN) cycle
//   period        : latched period; an effective period of max(period,1) is used
//   tick          : registered, high in every running cycle whose count is P-1
//   clk_out       : toggles on the same edge that raises tick; never cleared
//                   except by reset, so it keeps its level between jobs
// The count and tick are computed one edge ahead so that tick is a register
// and still lands in the very first RUN cycle when P is 1.
module tick_div
  import uart_clock_arbiter_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                hwclk,
  input  logic                resetn,
  input  logic                clear,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick,
  output logic                clk_out
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] cnt_d;
  logic [PERIOD_W-1:0] last_cnt;
  logic                tick_d;

  // A zero period behaves as a period of one: tick every running cycle.
  assign last_cnt = (period == '0) ? '0 : period - PERIOD_W'(1);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (run) begin
      if (clear || cnt == last_cnt) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt + PERIOD_W'(1);
      end
      tick_d = (cnt_d == last_cnt);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      tick    <= tick_d;
      clk_out <= clk_out ^ tick_d;
    end
  end

endmodule

// File: rtl/uart_clock_arbiter.sv
// Round-robin arbiter that lends one tick divider to NREQ requesters.
//   hwclk, resetn : clock and async active-low reset
//   bus           : requester bundle (req/period/nticks in; grant/tick/
//                   clk_out/done/busy out), see uart_clock_arbiter_if
// A winner is chosen in IDLE starting after the previous owner, its period
// and tick count are latched, and the divider runs until the requested number
// of ticks has been produced (done pulse) or the owner drops req (silent
// abort). All outputs are registered.
module uart_clock_arbiter
  import uart_clock_arbiter_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int COUNT_W  = DEF_COUNT_W
) (
  input logic                 hwclk,
  input logic                 resetn,
  uart_clock_arbiter_if.slave bus
);

  localparam int OWN_W = $clog2(NREQ);
  typedef logic [OWN_W-1:0] own_t;

  state_t              state;
  state_t              state_d;
  own_t                owner;
  own_t                last_owner;
  own_t                winner;
  own_t                idx;
  logic                found;
  logic [PERIOD_W-1:0] period_l;
  logic [COUNT_W-1:0]  nticks_l;
  logic [COUNT_W-1:0]  tick_cnt;
  logic                owner_req;
  logic                last_tick;
  logic                abort;
  logic                div_clear;
  logic                div_run;
  logic                tick;
  logic                clk_out;
  logic [NREQ-1:0]     grant_q;
  logic [NREQ-1:0]     grant_d;
  logic [NREQ-1:0]     done_q;
  logic [NREQ-1:0]     done_d;
  logic                busy_q;
  logic                busy_d;

  // Round-robin search: first active request after last_owner, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = last_owner;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = own_t'((int'(last_owner) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign owner_req = bus.req[owner];
  assign abort     = (state == LOAD || state == RUN) && !owner_req;
  // Only evaluated in RUN, where nticks_l is at least one.
  assign last_tick = tick && (tick_cnt == nticks_l - COUNT_W'(1));

  // State register.
  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic. Losing the owner's request wins over completion.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (found) state_d = LOAD;
      LOAD: begin
        if (!owner_req)            state_d = IDLE;
        else if (nticks_l == '0)   state_d = DONE;
        else                       state_d = RUN;
      end
      RUN: begin
        if (!owner_req)            state_d = IDLE;
        else if (last_tick)        state_d = DONE;
      end
      DONE:                        state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Owner bookkeeping and the job parameters latched at grant time; later
  // changes on period/nticks are ignored until the next grant.
  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      owner      <= '0;
      last_owner <= own_t'(NREQ - 1);
      period_l   <= '0;
      nticks_l   <= '0;
      tick_cnt   <= '0;
    end else begin
      if (state == IDLE && found) begin
        owner    <= winner;
        period_l <= bus.period[int'(winner)*PERIOD_W +: PERIOD_W];
        nticks_l <= bus.nticks[int'(winner)*COUNT_W +: COUNT_W];
      end
      if (state == LOAD) begin
        tick_cnt <= '0;
      end else if (state == RUN && tick) begin
        tick_cnt <= tick_cnt + COUNT_W'(1);
      end
      if (state == DONE || abort) begin
        last_owner <= owner;
      end
    end
  end

  // Output decode from the upcoming state; registered below.
  always_comb begin
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = (state_d != IDLE);
    if (state_d == IDLE) begin
      grant_d = '0;
    end else if (state == IDLE) begin
      grant_d         = '0;
      grant_d[winner] = 1'b1;
    end
    if (state_d == DONE) begin
      done_d[owner] = 1'b1;
    end
  end

  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign div_clear = (state == LOAD);
  assign div_run   = (state_d == RUN);

  tick_div #(
    .PERIOD_W (PERIOD_W)
  ) u_tick_div (
    .hwclk   (hwclk),
    .resetn  (resetn),
    .clear   (div_clear),
    .run     (div_run),
    .period  (period_l),
    .tick    (tick),
    .clk_out (clk_out)
  );

  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.tick    = tick;
  assign bus.clk_out = clk_out;

endmodule

// File: tb/tb_uart_clock_arbiter.sv
// Self-checking bench for uart_clock_arbiter. A job-level reference model
// predicts every output each cycle from the grant cycle g, period P and tick
// count n of the current job: LOAD at g, ticks at g+k*P (k=1..n), DONE at
// g+n*P+1 (g+1 when n is 0), round-robin choice after the last owner.
module tb_uart_clock_arbiter;
  import uart_clock_arbiter_pkg::*;

  localparam int NREQ     = 2;
  localparam int PERIOD_W = 32;
  localparam int COUNT_W  = 8;

  logic hwclk  = 1'b0;
  logic resetn = 1'b1;

  always #5 hwclk = ~hwclk;

  uart_clock_arbiter_if #(.NREQ(NREQ), .PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) bus ();

  uart_clock_arbiter #(.NREQ(NREQ), .PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) dut (
    .hwclk  (hwclk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state.
  bit              active;
  int              o, g, n, p, e, last;
  logic            clkv;
  logic [NREQ-1:0] exp_grant, exp_done;
  logic            exp_tick, exp_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    active    = 1'b0;
    last      = NREQ - 1;
    clkv      = 1'b0;
    exp_grant = '0;
    exp_done  = '0;
    exp_tick  = 1'b0;
    exp_busy  = 1'b0;
  endtask

  // Called at each rising edge: inputs seen during the ending cycle decide
  // what happens in the cycle that starts now.
  task automatic model_edge();
    int c;
    int w;
    int i;
    c   = cyc;
    cyc = c + 1;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (!active) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        i = (last + k) % NREQ;
        if (w < 0 && bus.req[i]) w = i;
      end
      if (w >= 0) begin
        active = 1'b1;
        o = w;
        g = c + 1;
        p = int'(bus.period[w*PERIOD_W +: PERIOD_W]);
        if (p < 1) p = 1;
        n = int'(bus.nticks[w*COUNT_W +: COUNT_W]);
        e = (n == 0) ? g + 1 : g + n * p + 1;
      end
    end else if (c >= g && c < e && !bus.req[o]) begin
      active = 1'b0;
      last   = o;
    end else if (c == e) begin
      active = 1'b0;
      last   = o;
    end
    exp_grant = '0;
    exp_done  = '0;
    exp_tick  = 1'b0;
    exp_busy  = 1'b0;
    if (active) begin
      exp_grant[o] = 1'b1;
      exp_busy     = 1'b1;
      if (cyc == e) exp_done[o] = 1'b1;
      if (cyc > g && cyc < e && ((cyc - g) % p) == 0) exp_tick = 1'b1;
    end
    clkv = clkv ^ exp_tick;
  endtask

  task automatic compare();
    check("grant",   bus.grant,   exp_grant);
    check("tick",    bus.tick,    exp_tick);
    check("clk_out", bus.clk_out, clkv);
    check("done",    bus.done,    exp_done);
    check("busy",    bus.busy,    exp_busy);
  endtask

  // One clock: model at the rising edge, compare at the falling edge, then
  // a requester that has just been told done releases its request.
  task automatic step();
    @(posedge hwclk);
    model_edge();
    @(negedge hwclk);
    compare();
    for (int i = 0; i < NREQ; i++) begin
      if (exp_done[i]) bus.req[i] = 1'b0;
    end
  endtask

  task automatic set_req(input int i, input int per, input int nt);
    bus.period[i*PERIOD_W +: PERIOD_W] = PERIOD_W'(per);
    bus.nticks[i*COUNT_W +: COUNT_W]   = COUNT_W'(nt);
    bus.req[i]                         = 1'b1;
  endtask

  // Asynchronous reset pulse taken away from any clock edge; outputs are
  // checked right after assertion, then two clocks are spent in reset.
  task automatic pulse_reset();
    #2 resetn = 1'b0;
    #1 model_reset();
    compare();
    repeat (2) step();
    resetn = 1'b1;
  endtask

  task automatic settle();
    for (int t = 0; t < 80 && (bus.busy || bus.req != '0); t++) step();
    check("settle_idle", bus.busy, 1'b0);
  endtask

  task automatic test_basic();
    int n0, done_off, toggles;
    int tq[$];
    logic prev;
    set_req(0, 4, 3);
    n0 = cyc; done_off = -1; toggles = 0; prev = bus.clk_out;
    for (int t = 0; t < 30 && done_off < 0; t++) begin
      step();
      if (cyc - n0 == 1) check("b_grant_lat", bus.grant, 2'b01);
      if (bus.tick) tq.push_back(cyc - n0);
      if (bus.clk_out !== prev) toggles++;
      prev = bus.clk_out;
      if (bus.done[0]) done_off = cyc - n0;
    end
    check("b_ticks", tq.size(), 3);
    check("b_tick1", (tq.size() > 0) ? tq[0] : -1, 5);
    check("b_tick2", (tq.size() > 1) ? tq[1] : -1, 9);
    check("b_tick3", (tq.size() > 2) ? tq[2] : -1, 13);
    check("b_done_at", done_off, 14);
    check("b_toggles", toggles, 3);
    settle();
  endtask

  task automatic test_rr();
    int order[$];
    int multi;
    multi = 0;
    set_req(0, 2, 1);
    set_req(1, 2, 1);
    pulse_reset();
    for (int t = 0; t < 40 && order.size() < 2; t++) begin
      step();
      if ($countones(bus.grant) > 1) multi++;
      if (bus.done[0]) order.push_back(0);
      if (bus.done[1]) order.push_back(1);
    end
    check("rr_count", order.size(), 2);
    check("rr_first", (order.size() > 0) ? order[0] : -1, 0);
    check("rr_second", (order.size() > 1) ? order[1] : -1, 1);
    check("rr_onehot", multi, 0);
    settle();
  endtask

  task automatic test_p0();
    int n0, done_off;
    int tq[$];
    set_req(0, 0, 2);
    n0 = cyc; done_off = -1;
    for (int t = 0; t < 20 && done_off < 0; t++) begin
      step();
      if (bus.tick) tq.push_back(cyc - n0);
      if (bus.done[0]) done_off = cyc - n0;
    end
    check("p0_ticks", tq.size(), 2);
    check("p0_tick1", (tq.size() > 0) ? tq[0] : -1, 2);
    check("p0_tick2", (tq.size() > 1) ? tq[1] : -1, 3);
    check("p0_done_at", done_off, 4);
    settle();
  endtask

  task automatic test_zero();
    int n0, done_off, nt;
    set_req(1, 3, 0);
    n0 = cyc; done_off = -1; nt = 0;
    for (int t = 0; t < 10 && done_off < 0; t++) begin
      step();
      if (bus.tick) nt++;
      if (bus.done[1]) done_off = cyc - n0;
    end
    check("z_ticks", nt, 0);
    check("z_done_at", done_off, 2);
    settle();
  endtask

  task automatic test_abort();
    int n0, rel, drop_off, g1, b1, g2, done0, done1;
    set_req(0, 10, 5);
    set_req(1, 2, 1);
    pulse_reset();
    n0 = cyc; drop_off = -1; g1 = -1; b1 = -1; g2 = -1; done0 = 0; done1 = -1;
    for (int t = 0; t < 60 && done1 < 0; t++) begin
      step();
      rel = cyc - n0;
      if (drop_off >= 0 && rel == drop_off + 1) begin
        g1 = int'(bus.grant);
        b1 = int'(bus.busy);
      end
      if (drop_off >= 0 && rel == drop_off + 2) g2 = int'(bus.grant);
      if (bus.done[0]) done0++;
      if (bus.done[1]) done1 = rel;
      if (drop_off < 0 && bus.tick) begin
        drop_off   = rel;
        bus.req[0] = 1'b0;
      end
    end
    check("ab_first_tick", drop_off, 11);
    check("ab_grant_idle", g1, 0);
    check("ab_busy_idle", b1, 0);
    check("ab_next_grant", g2, 2);
    check("ab_no_done0", done0, 0);
    check("ab_done1_at", done1, 16);
    settle();
  endtask

  task automatic test_reset();
    set_req(0, 3, 4);
    repeat (5) step();
    check("rst_busy_before", bus.busy, 1'b1);
    set_req(1, 2, 1);
    pulse_reset();
    step();
    check("rst_regrant", bus.grant, 2'b01);
    settle();
  endtask

  task automatic random_phase();
    for (int t = 0; t < 2000; t++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i]) begin
          if ($urandom_range(0, 5) == 0)
            set_req(i, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
        end else if ($urandom_range(0, 59) == 0) begin
          bus.req[i] = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          bus.period[i*PERIOD_W +: PERIOD_W] = PERIOD_W'($urandom_range(0, 7));
          bus.nticks[i*COUNT_W +: COUNT_W]   = COUNT_W'($urandom_range(0, 5));
        end
      end
    end
    bus.req = '0;
    settle();
  endtask

  initial begin
    bus.req    = '0;
    bus.period = '0;
    bus.nticks = '0;
    model_reset();
    #1 resetn = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    step();
    test_basic();
    test_rr();
    test_p0();
    test_zero();
    test_abort();
    test_reset();
    random_phase();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
